// File: rtl/parallel_serializer.sv
// Purpose: captures an N-bit parallel word and streams it LSB first on ser_out,
//          with an optional even-parity bit (build macro PARALLEL_SERIALIZER_PARITY_EN).
// Latency: first bit visible the cycle after capture; done pulses the cycle after the last bit.
// Backpressure: ser_en=0 holds the current bit indefinitely; din_ready is high only in IDLE.
module parallel_serializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         ser_en,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef PARALLEL_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   shift_reg;
    logic [CW-1:0]  cnt;
    logic           done_r;
    logic           capture;
    logic           advance;
    logic           frame_end;
`ifdef PARALLEL_SERIALIZER_PARITY_EN
    logic           parity_bit;
`endif

    // Next-state decode and Moore-style outputs; datapath strobes come out of here too.
    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    capture   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shift_reg[0];
                if (ser_en) begin
                    advance = 1'b1;
                    if (cnt == LAST) begin
`ifdef PARALLEL_SERIALIZER_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = IDLE;
                        frame_end = 1'b1;
`endif
                    end
                end
            end
`ifdef PARALLEL_SERIALIZER_PARITY_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_out   = parity_bit;
                if (ser_en) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift register and bit counter; counter saturates at N-1 so it never wraps in a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt       <= '0;
        end else if (capture) begin
            shift_reg <= din;
            cnt       <= '0;
        end else if (advance) begin
            shift_reg <= {1'b0, shift_reg[N-1:1]};
            cnt       <= (cnt == LAST) ? cnt : cnt + 1'b1;
        end
    end

    // Done is registered so it lands in the first IDLE cycle, alongside din_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= frame_end;
        end
    end

`ifdef PARALLEL_SERIALIZER_PARITY_EN
    // Parity is computed once from the captured word, since the shift register drains to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit <= 1'b0;
        end else if (capture) begin
            parity_bit <= ^din;
        end
    end
`endif

    assign done = done_r;

endmodule

// File: tb/tb_parallel_serializer.sv
// Bench for parallel_serializer with N=8: table-driven frames plus hand-written corner sequences.
// Captured words are pushed bit-by-bit into a scoreboard queue and popped as the stream is consumed.
// Works with or without PARALLEL_SERIALIZER_PARITY_EN defined.
module tb_parallel_serializer;

`ifdef PARALLEL_SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       ser_en;
    logic       ser_out;
    logic       ser_valid;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic       exp_q[$];
    logic [7:0] ds_sr = 8'h00;
    int         bit_idx = 0;
    int         done_total = 0;

    typedef struct {
        logic [7:0] din;
        bit         toggle;
        int         exp_valid;
        int         exp_done;
    } vec_t;

    vec_t vecs[4];

    parallel_serializer #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .ser_en    (ser_en),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
        if (P == 1) exp_q.push_back(^w);
    endtask

    // One clock: record a capture if the handshake completes at the coming edge.
    task automatic step();
        if (din_valid && din_ready) push_word(din);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        din_valid = 1'b0;
        ser_en    = 1'b1;
        n = 0;
        while (!din_ready && n < 100) begin
            step();
            n++;
        end
        if (!din_ready) chk("idle_timeout", 0, 1);
    endtask

    // Consumer model: scoreboard pop plus a downstream right shift register fed by data bits.
    always @(negedge clk) begin
        logic e;
        if (rst) begin
            bit_idx = 0;
        end else begin
            if (done) done_total++;
            if (ser_valid && ser_en) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ser_bit", int'(ser_out), int'(e));
                end
                if (bit_idx < 8) ds_sr = {ser_out, ds_sr[7:1]};
                bit_idx = (bit_idx == 8 + P - 1) ? 0 : bit_idx + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int rdy_bad;
        int done_n;
        int done_cyc;
        int d0;
        bit found;

        vecs[0] = '{8'hA5, 1'b0, 8 + P, 9 + P};
        vecs[1] = '{8'h81, 1'b1, 2 * (8 + P), 2 * (8 + P) + 1};
        vecs[2] = '{8'h07, 1'b0, 8 + P, 9 + P};
        vecs[3] = '{8'h03, 1'b1, 2 * (8 + P), 2 * (8 + P) + 1};

        rst = 1'b1; din = 8'h00; din_valid = 1'b0; ser_en = 1'b0;
        #3;
        chk("rst_din_ready", int'(din_ready), 1);
        chk("rst_ser_valid", int'(ser_valid), 0);
        chk("rst_ser_out", int'(ser_out), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // Table-driven frames: timing of ser_valid, din_ready and done per word.
        for (int v = 0; v < 4; v++) begin
            wait_idle();
            din = vecs[v].din; din_valid = 1'b1; ser_en = 1'b0;
            step();
            din_valid = 1'b0;
            vcnt = 0; rdy_bad = 0; done_n = 0; done_cyc = 0;
            for (int c = 1; c <= 40; c++) begin
                ser_en = vecs[v].toggle ? ((c % 2) == 0) : 1'b1;
                if (ser_valid) begin
                    vcnt++;
                    if (din_ready) rdy_bad++;
                end
                if (done) begin
                    done_n++;
                    done_cyc = c;
                end
                step();
            end
            chk("vec_valid_cycles", vcnt, vecs[v].exp_valid);
            chk("vec_done_count", done_n, 1);
            chk("vec_done_cycle", done_cyc, vecs[v].exp_done);
            chk("vec_ready_low", rdy_bad, 0);
            chk("vec_downstream", int'(ds_sr), int'(vecs[v].din));
        end

        // New word offered mid-frame must wait for IDLE.
        wait_idle();
        din = 8'h3C; din_valid = 1'b1;
        step();
        din = 8'hFF; ser_en = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            if (ser_valid) chk("midframe_ready", int'(din_ready), 0);
            step();
        end
        chk("midframe_done_seen", int'(found), 1);
        chk("midframe_first_word", int'(ds_sr), 8'h3C);
        step();
        wait_idle();
        chk("midframe_second_word", int'(ds_sr), 8'hFF);

        // Reset after the 4th bit of 0xF0 aborts the frame silently.
        din = 8'hF0; din_valid = 1'b1; ser_en = 1'b1;
        step();
        din_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("abort_ser_valid", int'(ser_valid), 0);
        chk("abort_din_ready", int'(din_ready), 1);
        chk("abort_done", int'(done), 0);
        exp_q.delete();
        d0 = done_total;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) step();
        chk("abort_no_done", done_total, d0);
        chk("abort_idle_ready", int'(din_ready), 1);
        din = 8'h01; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int c = 0; c < 14; c++) step();
        chk("after_abort_done", done_total, d0 + 1);
        chk("after_abort_word", int'(ds_sr), 8'h01);

        // Back-to-back frames with din_valid held high: one IDLE cycle between them.
        wait_idle();
        din = 8'h11; din_valid = 1'b1; ser_en = 1'b1;
        step();
        din = 8'h22;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("b2b_done_seen", int'(found), 1);
        chk("b2b_done_with_ready", int'(din_ready), 1);
        chk("b2b_first_word", int'(ds_sr), 8'h11);
        step();
        chk("b2b_one_idle_gap", int'(ser_valid), 1);
        din_valid = 1'b0;
        wait_idle();
        chk("b2b_second_word", int'(ds_sr), 8'h22);

        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parallel_serializer.md
PARALLEL_SERIALIZER -- requirements
Module: parallel_serializer

Interface
REQ-001 The block SHALL have parameter N, default 8: parallel word width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port din, input, N bits: parallel word to transmit.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din holds a word offered for capture.
REQ-006 The block SHALL have port din_ready, output, 1 bit: block can accept a word this cycle.
REQ-007 The block SHALL have port ser_en, input, 1 bit: downstream advance enable for the serial stream.
REQ-008 The block SHALL have port ser_out, output, 1 bit: serial data, LSB first, intended to drive a shift register's serial input.
REQ-009 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a frame bit this cycle.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last frame bit is consumed.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and PARITY, with PARITY present only under PARALLEL_SERIALIZER_PARITY_EN.
REQ-012 In IDLE: din_ready=1, ser_valid=0, ser_out=0.
REQ-013 In IDLE, din_valid=1 at a clk edge SHALL load din into an N-bit shift register, clear the bit counter and enter SHIFT on the same edge.
REQ-014 In SHIFT: din_ready=0, ser_valid=1, ser_out=shift_reg[0], which makes the first bit (din[0]) visible the cycle after capture.
REQ-015 In SHIFT, ser_en=1 at an edge SHALL shift the register right by one with 0 filled into the MSB and increment the counter.
REQ-016 In SHIFT, ser_en=0 SHALL hold the register, counter and ser_out unchanged for any number of cycles.
REQ-017 The counter SHALL be ceil(log2(N)) bits wide and range 0..N-1 with no wrap inside a frame.
REQ-018 When the counter equals N-1 and ser_en=1, the FSM SHALL go to PARITY if enabled, otherwise to IDLE with done=1 for the next cycle only.
REQ-019 Each frame SHALL carry exactly N data bits, each held valid until consumed by ser_en=1.
REQ-020 In PARITY: ser_valid=1, ser_out=even parity (XOR) of the captured word, and ser_en=1 SHALL go to IDLE with a done pulse.
REQ-021 din and din_valid SHALL be ignored outside IDLE, and the captured word SHALL NOT change mid-frame.
REQ-022 After a frame the block SHALL spend at least one cycle in IDLE, with done=1 coinciding with din_ready=1, so a word presented during the done cycle is captured at that edge.
REQ-023 Minimum frame period SHALL be N+1 cycles without parity and N+2 cycles with parity, with ser_en held at 1.

Reset
REQ-024 rst=1 SHALL force IDLE, clear the shift register and counter, and drive din_ready=1, ser_out=0, ser_valid=0, done=0, independent of clk.
REQ-025 rst asserted mid-frame SHALL abort the frame with no done pulse, and the first edge after release SHALL behave as IDLE.

Configuration
REQ-026 Macro PARALLEL_SERIALIZER_PARITY_EN defined SHALL append one even-parity bit per frame via the PARITY state.
REQ-027 With PARALLEL_SERIALIZER_PARITY_EN undefined, no PARITY state or parity logic SHALL exist and a frame SHALL be exactly N bits.

Verification (N=8)
REQ-028 The bench SHALL cover: din=8'hA5 with din_valid for 1 cycle, ser_en=1 constant -> ser_out over 8 cycles = 1,0,1,0,0,1,0,1; ser_valid high for exactly 8 cycles; done pulse on cycle 9; din_ready low for cycles 1-8.
REQ-029 The bench SHALL cover: din=8'h81 with ser_en toggling 1,0,1,0... -> each bit held 2 cycles, sequence 1,0,0,0,0,0,0,1, and exactly one done pulse.
REQ-030 The bench SHALL cover: new din=8'hFF with din_valid asserted during SHIFT of 8'h3C -> stream remains 0,0,1,1,1,1,0,0 and 8'hFF is captured only in IDLE.
REQ-031 The bench SHALL cover: rst pulsed after the 4th bit of 8'hF0 -> ser_valid=0 and din_ready=1 immediately, no done pulse, and the next word 8'h01 serializes correctly.
REQ-032 The bench SHALL cover, with PARALLEL_SERIALIZER_PARITY_EN: din=8'h07 -> 8 data bits then parity bit 1, ser_valid high for 9 cycles; din=8'h03 -> parity bit 0.
REQ-033 The bench SHALL cover: din_valid held high continuously with words 8'h11 and 8'h22 -> second word captured on the done cycle, frames separated by exactly one IDLE cycle, and a downstream 8-bit right shift register holds 8'h11 after the first frame.
